host_cmd_tx: RTL and testbench



---
 rtl/host_cmd_tx.sv | 191 +++++++++++++++++++
 tb/tb_host_cmd_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_tx.sv
// host_cmd_tx: serializes WRITE/READ/ALU_OP/ALU_NOP commands as UART frames (start, data LSB-first, opt. parity, stop).
// Latency: TX_OUT carries the start bit from the edge after accept; a command lasts N*(DATA_WIDTH+2+PAR_EN)*P clocks.
// Backpressure: cmd_ready only in IDLE, cmd_valid while busy is dropped; INTER_FRAME_GAP_EN adds a P-clock idle gap between frames.
module host_cmd_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5,
    parameter int ADDR_SIZE      = 4,
    parameter int ALU_FUN_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    input  logic [1:0]                cmd_type,
    input  logic [ADDR_SIZE-1:0]      addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    input  logic [ALU_FUN_WIDTH-1:0]  alu_fun,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      cmd_ready,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      byte_done,
    output logic                      cmd_done
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef INTER_FRAME_GAP_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

    typedef struct packed {
        logic [1:0]                cmd_type;
        logic [ADDR_SIZE-1:0]      addr;
        logic [DATA_WIDTH-1:0]     wr_data;
        logic [DATA_WIDTH-1:0]     op_a;
        logic [DATA_WIDTH-1:0]     op_b;
        logic [ALU_FUN_WIDTH-1:0]  alu_fun;
        logic                      par_en;
        logic                      par_typ;
        logic [PRESCALE_WIDTH-1:0] prescale;
    } cmd_t;

    state_t                    state_q, state_d;
    cmd_t                      cmd_q, cmd_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [1:0]                byte_q, byte_d;
    logic                      tx_q, tx_d;

    logic [PRESCALE_WIDTH-1:0] p_last;
    logic [1:0]                n_last;
    logic                      bit_end;
    logic                      last_byte;
    logic [DATA_WIDTH-1:0]     cur_byte_d;

    function automatic logic [DATA_WIDTH-1:0] frame_byte(input cmd_t c, input logic [1:0] idx);
        logic [DATA_WIDTH-1:0] b;
        b = '0;
        case (c.cmd_type)
            2'd0: case (idx)
                2'd0:    b = DATA_WIDTH'(8'hAA);
                2'd1:    b = DATA_WIDTH'(c.addr);
                default: b = c.wr_data;
            endcase
            2'd1: b = (idx == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(c.addr);
            2'd2: case (idx)
                2'd0:    b = DATA_WIDTH'(8'hCC);
                2'd1:    b = c.op_a;
                2'd2:    b = c.op_b;
                default: b = DATA_WIDTH'(c.alu_fun);
            endcase
            default: b = (idx == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(c.alu_fun);
        endcase
        return b;
    endfunction

    // prescale 0 behaves as 1: the last count of a bit is then 0
    assign p_last    = (cmd_q.prescale == '0) ? '0 : cmd_q.prescale - PRESCALE_WIDTH'(1);
    assign bit_end   = (cnt_q == p_last);
    assign n_last    = (cmd_q.cmd_type == 2'd0) ? 2'd2 :
                       (cmd_q.cmd_type == 2'd2) ? 2'd3 : 2'd1;
    assign last_byte = (byte_q == n_last);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + PRESCALE_WIDTH'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d          = S_START;
                    cmd_d.cmd_type   = cmd_type;
                    cmd_d.addr       = addr;
                    cmd_d.wr_data    = wr_data;
                    cmd_d.op_a       = op_a;
                    cmd_d.op_b       = op_b;
                    cmd_d.alu_fun    = alu_fun;
                    cmd_d.par_en     = PAR_EN;
                    cmd_d.par_typ    = PAR_TYP;
                    cmd_d.prescale   = prescale;
                    cnt_d            = '0;
                    bit_d            = '0;
                    byte_d           = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = cmd_q.par_en ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (last_byte) begin
                        state_d = S_IDLE;
                    end else begin
                        byte_d  = byte_q + 2'd1;
`ifdef INTER_FRAME_GAP_EN
                        state_d = S_GAP;
`else
                        state_d = S_START;
`endif
                    end
                end
            end
`ifdef INTER_FRAME_GAP_EN
            S_GAP: begin
                if (bit_end) state_d = S_START;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // TX_OUT is registered, so it is computed from the state being entered
        cur_byte_d = frame_byte(cmd_d, byte_d);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = cur_byte_d[bit_d];
            S_PARITY: tx_d = (^cur_byte_d) ^ cmd_d.par_typ;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = !cmd_ready;
    assign byte_done = (state_q == S_STOP) && bit_end;
    assign cmd_done  = byte_done && last_byte;
    assign TX_OUT    = tx_q;

endmodule

// File: tb/tb_host_cmd_tx.sv
// Bench for host_cmd_tx: per-cycle comparison of {TX_OUT,busy,cmd_ready,byte_done,cmd_done} against a frame-level model.
module tb_host_cmd_tx;
    localparam int DW = 8;
    localparam int PW = 5;
    localparam int AW = 4;
    localparam int FW = 4;
`ifdef INTER_FRAME_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_type = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic [FW-1:0] alu_fun = '0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic          cmd_ready, TX_OUT, busy, byte_done, cmd_done;

    always #5 CLK = ~CLK;

    host_cmd_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .ADDR_SIZE(AW), .ALU_FUN_WIDTH(FW)) dut (
        .CLK(CLK), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .addr(addr),
        .wr_data(wr_data), .op_a(op_a), .op_b(op_b), .alu_fun(alu_fun), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .prescale(prescale), .cmd_ready(cmd_ready), .TX_OUT(TX_OUT),
        .busy(busy), .byte_done(byte_done), .cmd_done(cmd_done)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [4:0] exp_q[$];

    function automatic logic [4:0] obs_vec();
        return {TX_OUT, busy, cmd_ready, byte_done, cmd_done};
    endfunction

    // Expected per-cycle outputs from the cycle after accept, ending with one idle cycle.
    function automatic void build_exp(input logic [1:0] t, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                      input logic [DW-1:0] oa, input logic [DW-1:0] ob, input logic [FW-1:0] fn,
                                      input logic pen, input logic ptyp, input logic [PW-1:0] ps);
        logic [DW-1:0] bq[$];
        logic          fb[$];
        logic          bd;
        int            p, nb, nf;
        exp_q.delete();
        p = (ps == 0) ? 1 : int'(ps);
        case (t)
            2'd0: begin bq.push_back(8'hAA); bq.push_back(DW'(a)); bq.push_back(wd); end
            2'd1: begin bq.push_back(8'hBB); bq.push_back(DW'(a)); end
            2'd2: begin bq.push_back(8'hCC); bq.push_back(oa); bq.push_back(ob); bq.push_back(DW'(fn)); end
            default: begin bq.push_back(8'hDD); bq.push_back(DW'(fn)); end
        endcase
        nb = bq.size();
        for (int i = 0; i < nb; i++) begin
            fb.delete();
            fb.push_back(1'b0);
            for (int j = 0; j < DW; j++) fb.push_back(bq[i][j]);
            if (pen) fb.push_back((^bq[i]) ^ ptyp);
            fb.push_back(1'b1);
            nf = fb.size();
            for (int j = 0; j < nf; j++) begin
                for (int c = 0; c < p; c++) begin
                    bd = (j == nf - 1) && (c == p - 1);
                    exp_q.push_back({fb[j], 1'b1, 1'b0, bd, bd && (i == nb - 1)});
                end
            end
            if (GAP_EN && i != nb - 1) begin
                for (int c = 0; c < p; c++) exp_q.push_back(5'b11000);
            end
        end
        exp_q.push_back(5'b10100);
    endfunction

    task automatic drive(input logic [1:0] t, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] oa, input logic [DW-1:0] ob, input logic [FW-1:0] fn,
                         input logic pen, input logic ptyp, input logic [PW-1:0] ps);
        cmd_type = t; addr = a; wr_data = wd; op_a = oa; op_b = ob; alu_fun = fn;
        PAR_EN = pen; PAR_TYP = ptyp; prescale = ps; cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (obs_vec() !== 5'b10100) begin
            n_fail++; $display("FAIL reset_hold got=%b exp=%b", obs_vec(), 5'b10100);
        end
        @(negedge CLK); rst_n = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (obs_vec() !== 5'b10100) begin
            n_fail++; $display("FAIL reset_release got=%b exp=%b", obs_vec(), 5'b10100);
        end
    endtask

    task automatic test_write();
        int done_at = 0, n_bd = 0;
        build_exp(2'd0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 5'd8);
        drive(2'd0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 5'd8);
        @(negedge CLK); cmd_valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge CLK);
            n_checks++;
            if (obs_vec() !== exp_q[k]) begin
                n_fail++; $display("FAIL write_wave cyc=%0d got=%b exp=%b", k + 1, obs_vec(), exp_q[k]);
            end
            if (cmd_done === 1'b1) done_at = k + 1;
            if (byte_done === 1'b1) n_bd++;
        end
        n_checks++;
        if (done_at !== (GAP_EN ? 256 : 240)) begin
            n_fail++; $display("FAIL write_duration got=%0d exp=%0d", done_at, GAP_EN ? 256 : 240);
        end
        n_checks++;
        if (n_bd !== 3) begin
            n_fail++; $display("FAIL write_byte_done_count got=%0d exp=3", n_bd);
        end
    endtask

    task automatic test_read_parity();
        int done_at = 0;
        logic par0 = 1'bx, par1 = 1'bx;
        int f1 = 44 + (GAP_EN ? 4 : 0);
        build_exp(2'd1, 4'd3, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 5'd4);
        drive(2'd1, 4'd3, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 5'd4);
        @(negedge CLK); cmd_valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge CLK);
            n_checks++;
            if (obs_vec() !== exp_q[k]) begin
                n_fail++; $display("FAIL read_wave cyc=%0d got=%b exp=%b", k + 1, obs_vec(), exp_q[k]);
            end
            if (k == 37) par0 = TX_OUT;
            if (k == f1 + 37) par1 = TX_OUT;
            if (cmd_done === 1'b1) done_at = k + 1;
        end
        n_checks++;
        if (par0 !== 1'b0) begin n_fail++; $display("FAIL read_parity_bb got=%b exp=0", par0); end
        n_checks++;
        if (par1 !== 1'b0) begin n_fail++; $display("FAIL read_parity_03 got=%b exp=0", par1); end
        n_checks++;
        if (done_at !== (GAP_EN ? 92 : 88)) begin
            n_fail++; $display("FAIL read_duration got=%0d exp=%0d", done_at, GAP_EN ? 92 : 88);
        end
    endtask

    task automatic test_nop_odd_parity();
        logic par0 = 1'bx, par1 = 1'bx;
        int f1 = 22 + (GAP_EN ? 2 : 0);
        build_exp(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd1, 1'b1, 1'b1, 5'd2);
        drive(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd1, 1'b1, 1'b1, 5'd2);
        @(negedge CLK); cmd_valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge CLK);
            n_checks++;
            if (obs_vec() !== exp_q[k]) begin
                n_fail++; $display("FAIL nop_wave cyc=%0d got=%b exp=%b", k + 1, obs_vec(), exp_q[k]);
            end
            if (k == 18) par0 = TX_OUT;
            if (k == f1 + 18) par1 = TX_OUT;
        end
        n_checks++;
        if (par0 !== 1'b1) begin n_fail++; $display("FAIL nop_parity_dd got=%b exp=1", par0); end
        n_checks++;
        if (par1 !== 1'b0) begin n_fail++; $display("FAIL nop_parity_01 got=%b exp=0", par1); end
    endtask

    task automatic test_reset_midframe();
        logic [AW-1:0] ra;
        drive(2'd2, 4'd0, 8'h00, DW'($urandom), DW'($urandom), FW'($urandom), 1'b0, 1'b0, 5'd4);
        @(negedge CLK); cmd_valid = 1'b0;
        repeat (9) @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b0) begin n_fail++; $display("FAIL midframe_bit1 got=%b exp=0", TX_OUT); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== 5'b10100) begin
            n_fail++; $display("FAIL async_reset got=%b exp=%b", obs_vec(), 5'b10100);
        end
        @(negedge CLK); rst_n = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            n_checks++;
            if (obs_vec() !== 5'b10100) begin
                n_fail++; $display("FAIL no_resume got=%b exp=%b", obs_vec(), 5'b10100);
            end
        end
        ra = AW'($urandom);
        build_exp(2'd1, ra, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b1, 5'd3);
        drive(2'd1, ra, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b1, 5'd3);
        @(negedge CLK); cmd_valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge CLK);
            n_checks++;
            if (obs_vec() !== exp_q[k]) begin
                n_fail++; $display("FAIL post_reset_wave cyc=%0d got=%b exp=%b", k + 1, obs_vec(), exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e1[$];
        logic [DW-1:0] a2, b2;
        logic [FW-1:0] f2;
        a2 = DW'($urandom); b2 = DW'($urandom); f2 = FW'($urandom);
        build_exp(2'd0, 4'd9, 8'h5A, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 5'd3);
        e1 = exp_q;
        build_exp(2'd2, 4'd0, 8'h00, a2, b2, f2, 1'b0, 1'b1, 5'd2);
        drive(2'd0, 4'd9, 8'h5A, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 5'd3);
        @(negedge CLK);
        // cmd_valid stays high; fields change mid-command
        drive(2'd2, 4'd0, 8'h00, a2, b2, f2, 1'b0, 1'b1, 5'd2);
        for (int k = 0; k < e1.size(); k++) begin
            if (k > 0) @(negedge CLK);
            n_checks++;
            if (obs_vec() !== e1[k]) begin
                n_fail++; $display("FAIL b2b_first cyc=%0d got=%b exp=%b", k + 1, obs_vec(), e1[k]);
            end
        end
        @(negedge CLK); cmd_valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge CLK);
            n_checks++;
            if (obs_vec() !== exp_q[k]) begin
                n_fail++; $display("FAIL b2b_second cyc=%0d got=%b exp=%b", k + 1, obs_vec(), exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] t; logic [AW-1:0] a; logic [DW-1:0] wd, oa, ob; logic [FW-1:0] fn;
        logic pen, ptyp; logic [PW-1:0] ps;
        for (int n = 0; n < 20; n++) begin
            t = 2'($urandom_range(0, 3)); a = AW'($urandom); wd = DW'($urandom);
            oa = DW'($urandom); ob = DW'($urandom); fn = FW'($urandom);
            pen = 1'($urandom); ptyp = 1'($urandom);
            ps = (n == 0) ? 5'd0 : PW'($urandom_range(0, 5));
            build_exp(t, a, wd, oa, ob, fn, pen, ptyp, ps);
            drive(t, a, wd, oa, ob, fn, pen, ptyp, ps);
            @(negedge CLK); cmd_valid = 1'b0;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (k > 0) @(negedge CLK);
                n_checks++;
                if (obs_vec() !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL random_wave cmd=%0d type=%0d ps=%0d cyc=%0d got=%b exp=%b",
                             n, t, ps, k + 1, obs_vec(), exp_q[k]);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_parity();
        test_nop_odd_parity();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
